// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event conditioner and its per-key channels.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } key_state_e;

    // Ceiling log2 that never returns less than 1, so single-value counters still get a bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/keypad_event_channel.sv
// One key: synchroniser, debounce counter and press/hold/auto-repeat state machine.
module keypad_event_channel
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    input  logic repeat_en,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int DB_W    = clog2_min1(DEBOUNCE_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = clog2_min1(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;
    key_state_e             state_q, state_d;
    logic [RPT_W-1:0]       rpt_cnt_q, rpt_cnt_d;
    logic                   synced;
    logic                   accept;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], key_raw};
        db_cnt_d  = '0;
        level_d   = level_q;
        accept    = 1'b0;
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        repeat_d  = 1'b0;

        // Any cycle where the synchronised line agrees with the level restarts the count.
        if (synced != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                accept  = 1'b1;
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end

        press_d   = accept & ~level_q;
        release_d = accept & level_q;

        case (state_q)
            IDLE: begin
                if (press_d) begin
                    state_d   = HELD_DELAY;
                    rpt_cnt_d = '0;
                end
            end
            HELD_DELAY: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == DELAY_LAST) begin
                    repeat_d  = repeat_en;
                    state_d   = HELD_REPEAT;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            HELD_REPEAT: begin
                if (release_d) begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end else if (rpt_cnt_q == PERIOD_LAST) begin
                    // Slots keep advancing while gated so repeats resume on schedule.
                    repeat_d  = repeat_en;
                    rpt_cnt_d = '0;
                end else begin
                    rpt_cnt_d = rpt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                rpt_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            state_q   <= IDLE;
            rpt_cnt_q <= '0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            state_q   <= state_d;
            rpt_cnt_q <= rpt_cnt_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/keypad_event_conditioner.sv
// Multi-key front end: one conditioning channel per key plus a registered lowest-index event encoder.
module keypad_event_conditioner
    import keypad_pkg::*;
#(
    parameter int N_KEYS          = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 50,
    parameter int REPEAT_PERIOD   = 10,
    parameter int CODE_W          = clog2_min1(N_KEYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    input  logic              repeat_en,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] repeat_pulse,
    output logic              event_valid,
    output logic [CODE_W-1:0] event_code
);

    logic [N_KEYS-1:0] event_any;
    logic              event_valid_q, event_valid_d;
    logic [CODE_W-1:0] event_code_q, event_code_d;

    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
            keypad_event_channel #(
                .SYNC_STAGES    (SYNC_STAGES),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_chan (
                .clk          (clk),
                .rst_n        (rst_n),
                .key_raw      (key_raw[gi]),
                .repeat_en    (repeat_en),
                .key_level    (key_level[gi]),
                .press_pulse  (press_pulse[gi]),
                .release_pulse(release_pulse[gi]),
                .repeat_pulse (repeat_pulse[gi])
            );
        end
    endgenerate

    assign event_any = press_pulse | repeat_pulse;

    // Scanning downward lets the lowest set index overwrite higher ones.
    always_comb begin
        event_valid_d = |event_any;
        event_code_d  = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (event_any[i]) begin
                event_code_d = CODE_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            event_valid_q <= 1'b0;
            event_code_q  <= '0;
        end else begin
            event_valid_q <= event_valid_d;
            event_code_q  <= event_code_d;
        end
    end

    assign event_valid = event_valid_q;
    assign event_code  = event_code_q;

endmodule

// File: tb/tb_keypad_event_conditioner.sv
// Directed and random stimulus for the keypad conditioner, checked against a cycle-history reference model.
module tb_keypad_event_conditioner;

    localparam int N  = 16;
    localparam int S  = 2;
    localparam int DB = 4;
    localparam int RD = 50;
    localparam int RP = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  key_raw;
    logic          repeat_en;
    logic [N-1:0]  key_level, press_pulse, release_pulse, repeat_pulse;
    logic          event_valid;
    logic [3:0]    event_code;

    always #5 clk = ~clk;

    keypad_event_conditioner #(
        .N_KEYS(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_raw      (key_raw),
        .repeat_en    (repeat_en),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .repeat_pulse (repeat_pulse),
        .event_valid  (event_valid),
        .event_code   (event_code)
    );

    // Reference model: raw sample history, run-length debounce, age-since-press repeat schedule.
    logic [N-1:0] raw_hist[$];
    logic [N-1:0] m_level, m_press, m_release, m_repeat;
    logic         m_valid;
    logic [3:0]   m_code;
    int           run_len[N];
    int           press_cyc[N];
    bit           held[N];
    int           cyc;
    int           n_assert;
    int           n_fail;

    task automatic model_reset();
        raw_hist = {};
        for (int i = 0; i < S; i++) raw_hist.push_front('0);
        m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
        m_valid = 1'b0; m_code = '0;
        for (int k = 0; k < N; k++) begin
            run_len[k] = 0; held[k] = 1'b0; press_cyc[k] = 0;
        end
    endtask

    task automatic model_update();
        logic [N-1:0] synced, prev_ev;
        int age;
        cyc++;
        if (!rst_n) begin
            model_reset();
            return;
        end
        prev_ev = m_press | m_repeat;
        m_valid = |prev_ev;
        m_code  = '0;
        for (int i = 0; i < N; i++) begin
            if (prev_ev[i]) begin
                m_code = 4'(i);
                break;
            end
        end
        synced = raw_hist[S-1];
        raw_hist.push_front(key_raw);
        void'(raw_hist.pop_back());
        m_press = '0; m_release = '0; m_repeat = '0;
        for (int k = 0; k < N; k++) begin
            if (synced[k] != m_level[k]) begin
                run_len[k]++;
                if (run_len[k] == DB) begin
                    m_level[k] = ~m_level[k];
                    run_len[k] = 0;
                    if (m_level[k]) m_press[k] = 1'b1;
                    else            m_release[k] = 1'b1;
                end
            end else begin
                run_len[k] = 0;
            end
            if (m_press[k]) begin
                held[k] = 1'b1;
                press_cyc[k] = cyc;
            end
            if (m_release[k]) held[k] = 1'b0;
            age = cyc - press_cyc[k];
            if (held[k] && age >= RD && ((age - RD) % RP) == 0 && repeat_en)
                m_repeat[k] = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("key_level", 32'(key_level), 32'(m_level));
        chk("press_pulse", 32'(press_pulse), 32'(m_press));
        chk("release_pulse", 32'(release_pulse), 32'(m_release));
        chk("repeat_pulse", 32'(repeat_pulse), 32'(m_repeat));
        chk("event_valid", 32'(event_valid), 32'(m_valid));
        chk("event_code", 32'(event_code), 32'(m_code));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_assert = 0; n_fail = 0; cyc = 0;
        rst_n = 1'b0; key_raw = '1; repeat_en = 1'b1;
        model_reset();

        // Reset with every key held: outputs stay zero, then a full-latency press on all keys.
        run(3);
        chk("reset_outputs", {press_pulse, key_level}, 32'h0);
        chk("reset_event", {28'h0, event_code} | 32'(event_valid), 32'h0);
        rst_n = 1'b1;
        run(5);
        chk("reset_no_early_press", 32'(press_pulse), 32'h0);
        step();
        chk("reset_press_all", 32'(press_pulse), 32'h0000_FFFF);
        key_raw = '0;
        run(12);

        // Bounce on key 3: 3 high, 1 low, then held high.
        key_raw[3] = 1'b1; run(3);
        key_raw[3] = 1'b0; run(1);
        key_raw[3] = 1'b1; run(5);
        chk("bounce_no_early", 32'(press_pulse[3]), 32'h0);
        step();
        chk("bounce_press", 32'(press_pulse[3]), 32'h1);
        chk("bounce_level", 32'(key_level[3]), 32'h1);
        key_raw[3] = 1'b0; run(12);

        // Auto-repeat on key 0 at +50, then every +10 up to +100.
        key_raw[0] = 1'b1; run(6);
        chk("rpt_press", 32'(press_pulse[0]), 32'h1);
        run(49); step();
        chk("rpt_first", 32'(repeat_pulse[0]), 32'h1);
        for (int r = 0; r < 5; r++) begin
            run(9); step();
            chk("rpt_next", 32'(repeat_pulse[0]), 32'h1);
        end
        key_raw[0] = 1'b0; run(6);
        chk("rpt_release", 32'(release_pulse[0]), 32'h1);
        run(60);

        // Gating on key 5: repeat_en low for +40..+64, next pulse at +70.
        key_raw[5] = 1'b1; run(6);
        run(39);
        repeat_en = 1'b0; run(10);
        chk("gate_none_50", 32'(repeat_pulse[5]), 32'h0);
        run(15);
        repeat_en = 1'b1; run(5);
        step();
        chk("gate_resume_70", 32'(repeat_pulse[5]), 32'h1);
        key_raw[5] = 1'b0; run(12);

        // Simultaneous press on keys 2 and 9.
        key_raw[2] = 1'b1; key_raw[9] = 1'b1; run(5);
        step();
        chk("simul_press", 32'(press_pulse), 32'h0000_0204);
        step();
        chk("simul_valid", 32'(event_valid), 32'h1);
        chk("simul_code", 32'(event_code), 32'h2);
        key_raw[2] = 1'b0; key_raw[9] = 1'b0; run(12);

        // Reset at +55 while key 1 is repeating.
        key_raw[1] = 1'b1; run(6); run(55);
        rst_n = 1'b0; step();
        chk("midrst_release", 32'(release_pulse), 32'h0);
        chk("midrst_level", 32'(key_level), 32'h0);
        rst_n = 1'b1; run(5);
        step();
        chk("midrst_repress", 32'(press_pulse[1]), 32'h1);
        key_raw[1] = 1'b0; run(12);

        // Random traffic: low keys are long-held, high keys chatter.
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (k < 4) begin
                    if ($urandom_range(0, 149) == 0) key_raw[k] = ~key_raw[k];
                end else begin
                    if ($urandom_range(0, 11) == 0) key_raw[k] = ~key_raw[k];
                end
            end
            if ($urandom_range(0, 59) == 0) repeat_en = ~repeat_en;
            rst_n = ($urandom_range(0, 799) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_event_conditioner.md
# keypad_event_conditioner

Parametrised multi-channel keypad front end. It synchronises and debounces N raw key lines and emits one-cycle press, release and auto-repeat pulses per key. It replaces the single-line one-shot press detector. It sits between the keypad pins and the game/motor control FSMs, which consume only single-cycle event pulses and the lowest-index event code.

## Interface
Parameters:
- N_KEYS, 16: number of key channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised cycles required to accept a level change (≥1).
- REPEAT_DELAY, 50: cycles from press pulse to first repeat pulse (≥1).
- REPEAT_PERIOD, 10: cycles between subsequent repeat pulses (≥1).

Ports:
- clk, in, 1: single clock; all logic on posedge.
- rst_n, in, 1: synchronous, active-low reset.
- key_raw, in, N_KEYS: asynchronous raw key lines, 1 = pressed.
- repeat_en, in, 1: global auto-repeat enable, sampled every cycle.
- key_level, out, N_KEYS: debounced key state.
- press_pulse, out, N_KEYS: one-cycle pulse on accepted press.
- release_pulse, out, N_KEYS: one-cycle pulse on accepted release.
- repeat_pulse, out, N_KEYS: one-cycle auto-repeat pulse while held.
- event_valid, out, 1: OR of press_pulse and repeat_pulse across all keys.
- event_code, out, $clog2(N_KEYS) (min 1): index of the lowest key with press_pulse or repeat_pulse set; 0 when event_valid=0.

## Operation
- Per channel: synchroniser, then debounce counter, then FSM with states IDLE, HELD_DELAY, HELD_REPEAT.
- Debounce: the counter increments while the synchronised value differs from key_level and clears to 0 when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, key_level toggles on the next edge and the counter clears.
- A key_level rise produces press_pulse=1 in the same cycle key_level first reads 1. A fall produces release_pulse=1 in the same cycle key_level first reads 0.
- IDLE goes to HELD_DELAY on an accepted press; the repeat counter loads 0.
- HELD_DELAY: the counter counts. At REPEAT_DELAY the FSM emits repeat_pulse (only if repeat_en=1), goes to HELD_REPEAT and clears the counter.
- HELD_REPEAT: repeat_pulse every REPEAT_PERIOD cycles (when repeat_en=1).
- An accepted release in any held state returns to IDLE immediately. No repeat pulse occurs in or after the release cycle.
- When repeat_en=0, counters still run and states still advance, but repeat_pulse is gated to 0. Repeats resume on the next scheduled slot after repeat_en rises.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no output and no state change.
- Encoder: lowest index wins. Simultaneous events on other keys remain visible on the per-key vectors only.

## Timing
- Reset (rst_n=0 at a posedge): synchroniser flops, key_level, all pulse outputs, event_valid and event_code go to 0; counters go to 0; FSMs go to IDLE. Reset applies mid-debounce or mid-repeat with no release pulse.
- A key held high during reset is seen as a new press after reset deasserts, at full latency.
- Press latency: with key_raw rising before edge 0 and held, press_pulse is high in the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES-1. That is 6 cycles with the defaults. Release latency is identical.
- First repeat pulse: exactly REPEAT_DELAY cycles after the press pulse cycle. Subsequent repeat pulses: every REPEAT_PERIOD cycles.
- All outputs are registered. event_valid and event_code are registered from the same-cycle pulse vectors, so they lag those vectors by 1 cycle.
- Repeat counter width: $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1). It never wraps; it clears on each pulse slot.

## Structure
- keypad_pkg: state enum (IDLE, HELD_DELAY, HELD_REPEAT) and a clog2-with-minimum-1 width function.
- Sub-module keypad_event_channel, one per key (generate loop). It contains the synchroniser, debounce logic and FSM, and takes the counter parameters.
- The top level holds the generate loop, the lowest-index priority encoder and the event_valid register.

## Test plan
- Reset: assert rst_n=0 while key_raw=all-ones. All outputs read 0. After deassert, press_pulse=all-ones exactly 6 cycles later (defaults).
- Bounce: on key 3, toggle high for 3 cycles, low for 1, then hold high. No pulse during the bounce. One press_pulse[3] at 6 cycles after the final rise. key_level[3]=1.
- Auto-repeat: hold key 0 for 100 cycles after press with repeat_en=1. repeat_pulse[0] fires at +50, +60, +70, +80, +90, +100. Release gives one release_pulse[0] and no further repeats.
- Repeat gating: set repeat_en=0 from +40 to +65 while key 5 is held. There is no pulse at +50 or +60; the next pulse is at +70.
- Simultaneous press: keys 2 and 9 rise on the same edge. press_pulse[2] and press_pulse[9] both fire in the same cycle. One cycle later event_valid=1 and event_code=2.
- Mid-repeat reset: reset at +55 while holding key 1. Outputs go to 0 with no release pulse. A new press_pulse[1] comes 6 cycles after deassert.
